lap_stop_watch: RTL and testbench
=================================

Name: lap_stop_watch

Overview:
Parametrised stopwatch with centisecond resolution and full six-digit BCD display (MM:SS.cc). It adds a circular lap memory of configurable depth and a review mode for stepping through stored laps. It is driven by single-cycle, pre-debounced button pulses and feeds the FND display controller directly.

Parameters:
CLK_FREQ, 100000000, input clock frequency in Hz; tick prescale = CLK_FREQ/100 (must divide exactly).
LAP_DEPTH, 8, number of lap entries stored; must be at least 2.
MIN_WRAP, 60, minute count modulus; the minute field spans 0..MIN_WRAP-1 and MIN_WRAP must be 100 or less.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous reset, active-low (asserted at 0); all state is cleared while it is low.
btn_start  in  1  one-cycle pulse; start/pause toggle.
btn_lap  in  1  one-cycle pulse; record a lap in RUN, or step to the next entry in REVIEW.
btn_clear  in  1  one-cycle pulse; clear.
btn_recall  in  1  one-cycle pulse; enter or leave REVIEW.
value  out  24  {min10,min1,sec10,sec1,csec10,csec1}, BCD.
running  out  1  high in RUN.
reviewing  out  1  high in REVIEW.
lap_count  out  $clog2(LAP_DEPTH+1)  number of valid entries (saturates at LAP_DEPTH).
review_idx  out  $clog2(LAP_DEPTH)  entry being displayed; 0 = newest.
lap_full  out  1  high when lap_count == LAP_DEPTH.
overflow  out  1  sticky flag; set when the minute field wraps.

Behaviour:
- Reset values: state IDLE, time 00:00.00, prescaler 0, buffer empty, every output 0.
- Prescaler: counts only in RUN and emits a 1-cycle tick at count PRESCALE-1. Its count is held in PAUSE, so a resumed run keeps the partial interval. It is zeroed by clear.
- Time chain, on each tick:
  - csec counts 0..99.
  - Carry into sec, which counts 0..59.
  - Carry into min, which counts 0..MIN_WRAP-1.
  - min wrap returns the time to 00:00.00, sets overflow, and counting continues.
  - All digits are stored as BCD; no binary-to-BCD conversion.
- Button priority when pulses coincide: clear > start > lap > recall. Only the highest-priority pulse acts.
- State machine:
  - IDLE: time zero. start -> RUN. recall -> REVIEW if lap_count > 0, otherwise ignored. lap and clear have no effect.
  - RUN: start -> PAUSE. lap writes the current time into the buffer. clear and recall are ignored.
  - PAUSE: start -> RUN. clear -> IDLE, zeroing time, prescaler, buffer and overflow. recall -> REVIEW if lap_count > 0.
  - REVIEW:
    - review_idx is set to 0 on entry.
    - lap advances review_idx to the next older entry; past the oldest (lap_count-1) it wraps to 0.
    - recall returns to the state REVIEW was entered from (IDLE or PAUSE).
    - clear behaves as in PAUSE and goes to IDLE.
    - start is ignored.
- Lap write:
  - The stored value is the registered time at the edge where btn_lap is sampled, i.e. before any tick in that same cycle.
  - The write pointer increments modulo LAP_DEPTH.
  - lap_count saturates; when full, the oldest entry is overwritten.
- value: shows the buffer entry at (wr_ptr-1-review_idx) mod LAP_DEPTH in REVIEW, and the live time otherwise. Registered output, updated the cycle after the state or index change.
- If reset is asserted mid-run, everything clears immediately.

Optional Feature:
LAP_SPLIT_EN
- Defined: a second BCD chain, the split counter, advances on the same ticks. It is zeroed on every lap write and on clear. Lap entries store the split time (time since the previous lap, or since start for the first lap) instead of absolute elapsed time. Live value is unchanged.
- Undefined: no split chain; entries store absolute elapsed time.

Test Plan:
1. CLK_FREQ=1000 (prescale 10): release reset, pulse start, wait 1000 cycles -> value=0x000100 (00:01.00), running=1.
2. RUN to 00:00.50, pulse start, wait 200 cycles, pulse start, wait 500 cycles -> value=0x000100; partial prescale preserved across the pause.
3. LAP_DEPTH=4: five laps at 0.10 s intervals, then pause, recall -> lap_count=4, lap_full=1, value=0x000050; step with lap four times -> 0x000040, 0x000030, 0x000020, then wrap to 0x000050.
4. MIN_WRAP=2: run past 01:59.99 -> value=0x000000 and overflow=1; clear from PAUSE -> overflow=0, lap_count=0, value=0.
5. In PAUSE, pulse clear and start in the same cycle -> IDLE, value=0, running=0.
6. With LAP_SPLIT_EN: laps at 00:00.30 and 00:00.70 -> REVIEW shows 0x000040 at idx 0 and 0x000030 at idx 1.

Source files
------------

// File: rtl/lap_stop_watch.sv
// Centisecond stopwatch (MM:SS.cc, BCD) with a circular lap memory and a lap review mode.
// Define LAP_SPLIT_EN to store split times (time since the previous lap) instead of elapsed time.
module lap_stop_watch #(
  parameter int CLK_FREQ  = 100000000,
  parameter int LAP_DEPTH = 8,
  parameter int MIN_WRAP  = 60
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           btn_start,
  input  logic                           btn_lap,
  input  logic                           btn_clear,
  input  logic                           btn_recall,
  output logic [23:0]                    value,
  output logic                           running,
  output logic                           reviewing,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic [$clog2(LAP_DEPTH)-1:0]   review_idx,
  output logic                           lap_full,
  output logic                           overflow
);

  // state    | meaning
  // S_IDLE   | time held at zero, waiting for start
  // S_RUN    | prescaler and time chain advancing, laps recorded
  // S_PAUSE  | time frozen, prescaler phase kept
  // S_REVIEW | value shows a stored lap; returns to IDLE or PAUSE

  localparam int PRESCALE = CLK_FREQ / 100;
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int PTR_W    = $clog2(LAP_DEPTH);
  localparam int CNT_W    = $clog2(LAP_DEPTH + 1);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LAP_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAP_DEPTH);
  localparam logic [7:0]       MIN_LAST = {4'((MIN_WRAP - 1) / 10), 4'((MIN_WRAP - 1) % 10)};
  localparam logic [23:0]      T_LAST   = {MIN_LAST, 16'h5999};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_REVIEW} state_t;

  state_t           state_q, state_d;
  logic             ret_pause_q, ret_pause_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [23:0]      time_q, time_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic [23:0]      value_q, value_d;
  logic [23:0]      lap_mem_q [LAP_DEPTH];
  logic [23:0]      lap_mem_d [LAP_DEPTH];
`ifdef LAP_SPLIT_EN
  logic [23:0]      split_q, split_d;
`endif

  logic             tick, lap_wr, clear_all;
  logic             do_clear, do_start, do_lap, do_recall;
  logic [PTR_W:0]   rd_sum;
  logic [PTR_W-1:0] rd_idx;

  // BCD increment of MM:SS.cc; the minute field wraps to zero after MIN_WRAP-1.
  function automatic logic [23:0] time_next(input logic [23:0] t);
    logic [23:0] n;
    n = t;
    if (t[3:0] != 4'd9) n[3:0] = t[3:0] + 4'd1;
    else begin
      n[3:0] = 4'd0;
      if (t[7:4] != 4'd9) n[7:4] = t[7:4] + 4'd1;
      else begin
        n[7:4] = 4'd0;
        if (t[11:8] != 4'd9) n[11:8] = t[11:8] + 4'd1;
        else begin
          n[11:8] = 4'd0;
          if (t[15:12] != 4'd5) n[15:12] = t[15:12] + 4'd1;
          else begin
            n[15:12] = 4'd0;
            if (t[23:16] == MIN_LAST) n[23:16] = 8'h00;
            else if (t[19:16] != 4'd9) n[19:16] = t[19:16] + 4'd1;
            else begin
              n[19:16] = 4'd0;
              n[23:20] = t[23:20] + 4'd1;
            end
          end
        end
      end
    end
    return n;
  endfunction

  always_comb begin
    do_clear  = btn_clear;
    do_start  = btn_start & ~btn_clear;
    do_lap    = btn_lap & ~btn_start & ~btn_clear;
    do_recall = btn_recall & ~btn_lap & ~btn_start & ~btn_clear;
  end

  always_comb begin
    state_d     = state_q;
    ret_pause_d = ret_pause_q;
    ps_d        = ps_q;
    time_d      = time_q;
    ovf_d       = ovf_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    lap_mem_d   = lap_mem_q;
`ifdef LAP_SPLIT_EN
    split_d     = split_q;
`endif
    tick        = 1'b0;
    lap_wr      = 1'b0;
    clear_all   = 1'b0;

    if (state_q == S_RUN) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        tick = 1'b1;
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end

    if (tick) begin
      time_d = time_next(time_q);
      if (time_q == T_LAST) ovf_d = 1'b1;
`ifdef LAP_SPLIT_EN
      split_d = time_next(split_q);
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (do_start) state_d = S_RUN;
        else if (do_recall && cnt_q != '0) begin
          state_d     = S_REVIEW;
          ret_pause_d = 1'b0;
          idx_d       = '0;
        end
      end
      S_RUN: begin
        if (do_start) state_d = S_PAUSE;
        else if (do_lap) lap_wr = 1'b1;
      end
      S_PAUSE: begin
        if (do_clear) clear_all = 1'b1;
        else if (do_start) state_d = S_RUN;
        else if (do_recall && cnt_q != '0) begin
          state_d     = S_REVIEW;
          ret_pause_d = 1'b1;
          idx_d       = '0;
        end
      end
      S_REVIEW: begin
        if (do_clear) clear_all = 1'b1;
        else if (do_lap) begin
          if (CNT_W'(idx_q) + CNT_W'(1) == cnt_q) idx_d = '0;
          else idx_d = idx_q + 1'b1;
        end else if (do_recall) begin
          state_d = ret_pause_q ? S_PAUSE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (lap_wr) begin
`ifdef LAP_SPLIT_EN
      lap_mem_d[wr_ptr_q] = split_q;
      // Keep a tick landing on the lap edge so the next split stays exact.
      split_d = tick ? 24'h000001 : 24'h000000;
`else
      lap_mem_d[wr_ptr_q] = time_q;
`endif
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
    end

    if (clear_all) begin
      state_d   = S_IDLE;
      ps_d      = '0;
      time_d    = '0;
      ovf_d     = 1'b0;
      wr_ptr_d  = '0;
      cnt_d     = '0;
      idx_d     = '0;
      lap_mem_d = '{default: '0};
`ifdef LAP_SPLIT_EN
      split_d   = '0;
`endif
    end

    rd_sum = {1'b0, wr_ptr_q} + (PTR_W+1)'(LAP_DEPTH - 1) - {1'b0, idx_q};
    if (rd_sum >= (PTR_W+1)'(LAP_DEPTH)) rd_sum = rd_sum - (PTR_W+1)'(LAP_DEPTH);
    rd_idx  = rd_sum[PTR_W-1:0];
    value_d = (state_q == S_REVIEW) ? lap_mem_q[rd_idx] : time_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ret_pause_q <= 1'b0;
      ps_q        <= '0;
      time_q      <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      value_q     <= '0;
      lap_mem_q   <= '{default: '0};
`ifdef LAP_SPLIT_EN
      split_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ret_pause_q <= ret_pause_d;
      ps_q        <= ps_d;
      time_q      <= time_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      value_q     <= value_d;
      lap_mem_q   <= lap_mem_d;
`ifdef LAP_SPLIT_EN
      split_q     <= split_d;
`endif
    end
  end

  assign value      = value_q;
  assign running    = (state_q == S_RUN);
  assign reviewing  = (state_q == S_REVIEW);
  assign lap_count  = cnt_q;
  assign review_idx = idx_q;
  assign lap_full   = (cnt_q == CNT_FULL);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_lap_stop_watch.sv
// Bench for lap_stop_watch: centisecond/queue model checked every cycle, plus directed literal checks.
module tb_lap_stop_watch;
  localparam int CLK_FREQ  = 200;
  localparam int LAP_DEPTH = 4;
  localparam int MIN_WRAP  = 2;
  localparam int PRESCALE  = CLK_FREQ / 100;
  localparam int TOT_CS    = MIN_WRAP * 6000;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_REV = 3;
  localparam int A_NONE = 0, A_CLR = 1, A_START = 2, A_LAP = 3, A_RECALL = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0, btn_recall = 1'b0;
  logic [23:0] value;
  logic running, reviewing, lap_full, overflow;
  logic [$clog2(LAP_DEPTH+1)-1:0] lap_count;
  logic [$clog2(LAP_DEPTH)-1:0]   review_idx;

  int checks = 0;
  int errors = 0;

  lap_stop_watch #(.CLK_FREQ(CLK_FREQ), .LAP_DEPTH(LAP_DEPTH), .MIN_WRAP(MIN_WRAP)) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear), .btn_recall(btn_recall),
    .value(value), .running(running), .reviewing(reviewing), .lap_count(lap_count),
    .review_idx(review_idx), .lap_full(lap_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Model: elapsed time as plain centiseconds, laps as a newest-first queue.
  int m_st = M_IDLE, m_ret = M_IDLE, m_ps = 0, m_cs = 0, m_prev = 0, m_idx = 0;
  bit m_ovf = 1'b0;
  int m_laps[$];
  logic [23:0] m_value = '0;
  int ma_act, ma_disp, ma_entry;
  bit ma_tick;

  function automatic logic [23:0] to_bcd(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_clear();
    m_st = M_IDLE; m_cs = 0; m_ps = 0; m_ovf = 1'b0; m_prev = 0; m_idx = 0;
    m_laps.delete();
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_clear();
      m_ret = M_IDLE;
      m_value = '0;
    end else begin
      if (btn_clear) ma_act = A_CLR;
      else if (btn_start) ma_act = A_START;
      else if (btn_lap) ma_act = A_LAP;
      else if (btn_recall) ma_act = A_RECALL;
      else ma_act = A_NONE;

      ma_disp = (m_st == M_REV) ? m_laps[m_idx] : m_cs;
      ma_tick = 1'b0;
      if (m_st == M_RUN) begin
        if (m_ps == PRESCALE - 1) begin m_ps = 0; ma_tick = 1'b1; end
        else m_ps = m_ps + 1;
      end

      case (m_st)
        M_IDLE: begin
          if (ma_act == A_START) m_st = M_RUN;
          else if (ma_act == A_RECALL && m_laps.size() > 0) begin
            m_ret = M_IDLE; m_st = M_REV; m_idx = 0;
          end
        end
        M_RUN: begin
          if (ma_act == A_START) m_st = M_PAUSE;
          else if (ma_act == A_LAP) begin
`ifdef LAP_SPLIT_EN
            ma_entry = (m_cs - m_prev + TOT_CS) % TOT_CS;
`else
            ma_entry = m_cs;
`endif
            m_prev = m_cs;
            m_laps.push_front(ma_entry);
            if (m_laps.size() > LAP_DEPTH) void'(m_laps.pop_back());
          end
        end
        M_PAUSE: begin
          if (ma_act == A_CLR) model_clear();
          else if (ma_act == A_START) m_st = M_RUN;
          else if (ma_act == A_RECALL && m_laps.size() > 0) begin
            m_ret = M_PAUSE; m_st = M_REV; m_idx = 0;
          end
        end
        default: begin
          if (ma_act == A_CLR) model_clear();
          else if (ma_act == A_LAP) m_idx = (m_idx + 1) % m_laps.size();
          else if (ma_act == A_RECALL) m_st = m_ret;
        end
      endcase

      if (ma_tick) begin
        m_cs = m_cs + 1;
        if (m_cs == TOT_CS) begin m_cs = 0; m_ovf = 1'b1; end
      end
      m_value = to_bcd(ma_disp);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                     input logic [31:0] exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  always @(negedge clk) begin
    chk("value", 32'(value), 32'(m_value));
    chk("running", 32'(running), 32'(m_st == M_RUN));
    chk("reviewing", 32'(reviewing), 32'(m_st == M_REV));
    chk("lap_count", 32'(lap_count), 32'(m_laps.size()));
    chk("lap_full", 32'(lap_full), 32'(m_laps.size() == LAP_DEPTH));
    chk("review_idx", 32'(review_idx), 32'(m_idx));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  end

  task automatic pulse(input logic s, input logic l, input logic c, input logic r);
    @(negedge clk);
    btn_start = s; btn_lap = l; btn_clear = c; btn_recall = r;
    @(negedge clk);
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0; btn_recall = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    wait_cyc(3);
    lit("rst_value", 32'(value), 32'(m_value), 32'h000000);
    lit("rst_lap_count", 32'(lap_count), 32'(m_laps.size()), 0);
    reset = 1'b1;

    // Recall with an empty buffer is ignored
    pulse(0, 0, 0, 1); wait_cyc(1);
    lit("idle_recall_empty", 32'(reviewing), 32'(m_st == M_REV), 0);

    // One second of running
    pulse(1, 0, 0, 0); wait_cyc(201);
    lit("t1_value", 32'(value), 32'(m_value), 32'h000100);
    lit("t1_running", 32'(running), 32'(m_st == M_RUN), 1);

    // Pause mid-interval; the partial prescale count survives
    do_reset();
    pulse(1, 0, 0, 0); wait_cyc(99);
    pulse(1, 0, 0, 0); wait_cyc(100);
    lit("t2_paused", 32'(value), 32'(m_value), 32'h000050);
    pulse(1, 0, 0, 0); wait_cyc(100);
    lit("t2_resumed", 32'(value), 32'(m_value), 32'h000100);

    // Five laps into a four-entry buffer, then review
    do_reset();
    pulse(1, 0, 0, 0); wait_cyc(19);
    pulse(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(18);
      pulse(0, 1, 0, 0);
    end
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1); wait_cyc(1);
    lit("t3_count", 32'(lap_count), 32'(m_laps.size()), 4);
    lit("t3_full", 32'(lap_full), 32'(m_laps.size() == LAP_DEPTH), 1);
    lit("t3_newest", 32'(value), 32'(m_value), 32'h000050);
    begin
      logic [23:0] exp_seq [4];
      exp_seq = '{24'h000040, 24'h000030, 24'h000020, 24'h000050};
      for (int i = 0; i < 4; i++) begin
        pulse(0, 1, 0, 0); wait_cyc(1);
        lit($sformatf("t3_step%0d", i), 32'(value), 32'(m_value), 32'(exp_seq[i]));
      end
    end
    pulse(0, 0, 0, 1); wait_cyc(1);
    lit("t3_back_pause", 32'(reviewing), 32'(m_st == M_REV), 0);

    // Minute wrap and overflow, then clear from PAUSE
    do_reset();
    pulse(1, 0, 0, 0); wait_cyc(9);
    pulse(0, 1, 0, 0); wait_cyc(23988);
    lit("t4_last", 32'(value), 32'(m_value), 32'h015999);
    lit("t4_no_ovf", 32'(overflow), 32'(m_ovf), 0);
    wait_cyc(2);
    lit("t4_wrapped", 32'(value), 32'(m_value), 32'h000000);
    lit("t4_ovf", 32'(overflow), 32'(m_ovf), 1);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0); wait_cyc(1);
    lit("t4_clr_ovf", 32'(overflow), 32'(m_ovf), 0);
    lit("t4_clr_count", 32'(lap_count), 32'(m_laps.size()), 0);
    lit("t4_clr_value", 32'(value), 32'(m_value), 0);

    // Clear and start together in PAUSE: clear wins
    do_reset();
    pulse(1, 0, 0, 0); wait_cyc(10);
    pulse(0, 1, 0, 0); wait_cyc(20);
    pulse(1, 0, 0, 0);
    pulse(1, 0, 1, 0); wait_cyc(1);
    lit("t5_value", 32'(value), 32'(m_value), 0);
    lit("t5_running", 32'(running), 32'(m_st == M_RUN), 0);
    lit("t5_count", 32'(lap_count), 32'(m_laps.size()), 0);

    // Laps at 0.30 and 0.70
    do_reset();
    pulse(1, 0, 0, 0); wait_cyc(59);
    pulse(0, 1, 0, 0); wait_cyc(78);
    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1); wait_cyc(1);
`ifdef LAP_SPLIT_EN
    lit("t6_idx0", 32'(value), 32'(m_value), 32'h000040);
`else
    lit("t6_idx0", 32'(value), 32'(m_value), 32'h000070);
`endif
    pulse(0, 1, 0, 0); wait_cyc(1);
    lit("t6_idx1", 32'(value), 32'(m_value), 32'h000030);
    lit("t6_idx", 32'(review_idx), 32'(m_idx), 1);

    // Reset asserted mid-run clears immediately
    pulse(0, 0, 0, 1);
    pulse(1, 0, 0, 0); wait_cyc(50);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    lit("t7_value", 32'(value), 32'(m_value), 0);
    lit("t7_running", 32'(running), 32'(m_st == M_RUN), 0);
    lit("t7_count", 32'(lap_count), 32'(m_laps.size()), 0);
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
